// File: rtl/seg_stream_decoder_if.sv
// Bundles the digit/LED sample stream, the capture-FIFO read port and the decode status outputs.
// master = stream source and FIFO reader, slave = decoder.
interface seg_stream_decoder_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          en;
    logic [55:0]   digits_in;
    logic [7:0]    led_in;
    logic          rd_en;
    logic [3:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic [3:0]    char_code;
    logic          char_valid;
    logic          shift_err;
    logic          led_err;
    logic [15:0]   char_cnt;

    modport master (
        output en, digits_in, led_in, rd_en,
        input  rd_data, empty, full, fifo_cnt, overflow,
               char_code, char_valid, shift_err, led_err, char_cnt
    );

    modport slave (
        input  en, digits_in, led_in, rd_en,
        output rd_data, empty, full, fifo_cnt, overflow,
               char_code, char_valid, shift_err, led_err, char_cnt
    );
endinterface

// File: rtl/seg_stream_decoder.sv
// Decodes characters shifted into an 8-digit 7-segment stream and queues their codes.
// Latency 1 from a shift to char_code/char_valid; FIFO read is first-word-fall-through.
// No backpressure on the stream: a push into a full FIFO is dropped and flags overflow.
module seg_stream_decoder #(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_stream_decoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [55:0]   r_prev_digits;
    logic [7:0]    r_prev_led;
    logic [3:0]    r_char_code;
    logic          r_char_valid;
    logic          r_shift_err;
    logic          r_led_err;
    logic [15:0]   r_char_cnt;
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_overflow;
    logic [3:0]    r_last;

    logic          w_idle;
    logic          w_adj;
    logic          w_shift;
    logic          w_serr;
    logic          w_led_bad;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr;
    logic [3:0]    w_code;

    // Patterns are active-low, bit6=g .. bit0=a; all-lit decodes as B so code 8 never appears.
    function automatic logic [3:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode = 4'h0;
            7'b1111001: decode = 4'h1;
            7'b0100100: decode = 4'h2;
            7'b0110000: decode = 4'h3;
            7'b0011001: decode = 4'h4;
            7'b0010010: decode = 4'h5;
            7'b0000010: decode = 4'h6;
            7'b1111000: decode = 4'h7;
            7'b0010000: decode = 4'h9;
            7'b0001000: decode = 4'hA;
            7'b0000000: decode = 4'hB;
            7'b1000001: decode = 4'hC;
            7'b1111111: decode = 4'hD;
            7'b0111111: decode = 4'hE;
            default:    decode = 4'hF;
        endcase
    endfunction

    assign w_idle    = (bus.digits_in == r_prev_digits);
    assign w_adj     = (bus.digits_in[55:7] == r_prev_digits[48:0]);
    assign w_shift   = bus.en && !w_idle && w_adj;
    assign w_serr    = bus.en && !w_idle && !w_adj;
    // On a shift the LED bus must move with the digits; otherwise it must stay put.
    assign w_led_bad = bus.en && (w_shift ? (bus.led_in[7:1] != r_prev_led[6:0])
                                          : (bus.led_in != r_prev_led));
    assign w_code    = decode(bus.digits_in[6:0]);

    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_pop     = bus.rd_en && !w_empty;
    assign w_wr      = w_shift && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_digits <= '1;
            r_prev_led    <= '0;
            r_char_code   <= '0;
            r_char_valid  <= 1'b0;
            r_shift_err   <= 1'b0;
            r_led_err     <= 1'b0;
            r_char_cnt    <= '0;
        end else begin
            r_char_valid <= w_shift;
            r_shift_err  <= w_serr;
            r_led_err    <= w_led_bad;
            if (bus.en) begin
                r_prev_digits <= bus.digits_in;
                r_prev_led    <= bus.led_in;
            end
            if (w_shift) begin
                r_char_code <= w_code;
                if (r_char_cnt != 16'hFFFF) r_char_cnt <= r_char_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_last     <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_shift && !w_wr) r_overflow <= 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.rd_data    = w_empty ? r_last : r_mem[r_rd_ptr];
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.fifo_cnt   = r_cnt;
    assign bus.overflow   = r_overflow;
    assign bus.char_code  = r_char_code;
    assign bus.char_valid = r_char_valid;
    assign bus.shift_err  = r_shift_err;
    assign bus.led_err    = r_led_err;
    assign bus.char_cnt   = r_char_cnt;
endmodule

// File: tb/tb_seg_stream_decoder.sv
// Scoreboard bench: a reference model predicts pulses/counters and queues expected FIFO codes.
module tb_seg_stream_decoder;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    seg_stream_decoder_if #(.DEPTH(DEPTH)) bus ();

    seg_stream_decoder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    logic [6:0]  seg [16];
    logic [55:0] m_prev_d;
    logic [7:0]  m_prev_l;
    logic [3:0]  m_code;
    logic [15:0] m_cnt;
    logic        m_ovf;
    logic [3:0]  m_last;
    logic        m_have_last;
    logic [3:0]  q [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_d    = '1;
        m_prev_l    = '0;
        m_code      = '0;
        m_cnt       = '0;
        m_ovf       = 1'b0;
        m_have_last = 1'b0;
        q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_char_valid", bus.char_valid, 0);
        chk("rst_shift_err",  bus.shift_err, 0);
        chk("rst_led_err",    bus.led_err, 0);
        chk("rst_char_code",  bus.char_code, 0);
        chk("rst_char_cnt",   bus.char_cnt, 0);
        chk("rst_fifo_cnt",   bus.fifo_cnt, 0);
        chk("rst_empty",      bus.empty, 1);
        chk("rst_full",       bus.full, 0);
        chk("rst_overflow",   bus.overflow, 0);
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.rd_en = 1'b0; bus.digits_in = '1; bus.led_in = '0;
        rst = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic e, input logic [55:0] d, input logic [7:0] l,
                        input logic r, input logic [3:0] code);
        logic idle, shft, exp_cv, exp_se, exp_le;
        exp_cv = 1'b0; exp_se = 1'b0; exp_le = 1'b0;
        if (r && q.size() > 0) begin
            chk("rd_data_pop", bus.rd_data, q[0]);
            m_last = q.pop_front();
            m_have_last = 1'b1;
        end
        if (e) begin
            idle = (d == m_prev_d);
            shft = !idle && (d[55:7] == m_prev_d[48:0]);
            if (shft) begin
                exp_cv = 1'b1;
                m_code = code;
                if (m_cnt != 16'hFFFF) m_cnt++;
                if (q.size() < DEPTH) q.push_back(code);
                else m_ovf = 1'b1;
                exp_le = (l[7:1] != m_prev_l[6:0]);
            end else begin
                exp_se = !idle;
                exp_le = (l != m_prev_l);
            end
            m_prev_d = d;
            m_prev_l = l;
        end
        bus.en = e; bus.digits_in = d; bus.led_in = l; bus.rd_en = r;
        @(posedge clk); #1;
        chk("char_valid", bus.char_valid, exp_cv);
        chk("shift_err",  bus.shift_err, exp_se);
        chk("led_err",    bus.led_err, exp_le);
        chk("char_code",  bus.char_code, m_code);
        chk("char_cnt",   bus.char_cnt, m_cnt);
        chk("fifo_cnt",   bus.fifo_cnt, q.size());
        chk("full",       bus.full, q.size() == DEPTH);
        chk("empty",      bus.empty, q.size() == 0);
        chk("overflow",   bus.overflow, m_ovf);
        if (q.size() > 0)     chk("rd_data_head", bus.rd_data, q[0]);
        else if (m_have_last) chk("rd_data_hold", bus.rd_data, m_last);
    endtask

    task automatic shift_char(input logic [3:0] code, input logic ledbit, input logic r);
        step(1'b1, {m_prev_d[48:0], seg[code]}, {m_prev_l[6:0], ledbit}, r, code);
    endtask

    task automatic idle_step(input logic r);
        step(1'b1, m_prev_d, m_prev_l, r, 4'h0);
    endtask

    logic [3:0] seq [15];
    logic [6:0] junk;

    initial begin
        n_cmp = 0; n_err = 0;
        seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100; seg[3] = 7'b0110000;
        seg[4] = 7'b0011001; seg[5] = 7'b0010010; seg[6] = 7'b0000010; seg[7] = 7'b1111000;
        seg[8] = 7'b1010101; seg[9] = 7'b0010000; seg[10] = 7'b0001000; seg[11] = 7'b0000000;
        seg[12] = 7'b1000001; seg[13] = 7'b1111111; seg[14] = 7'b0111111; seg[15] = 7'b1010101;
        seq = '{4'hB, 4'hC, 4'hA, 4'hA, 4'hD, 4'h1, 4'h9, 4'h5, 4'h2, 4'hE, 4'h2, 4'h0, 4'h2, 4'h5, 4'hD};
        rst = 1'b0;
        model_reset();
        do_reset();

        // First character: all-lit digit decodes as B, LED bit 0 comes in with it.
        step(1'b1, {49'h1_FFFF_FFFF_FFFF, 7'b0000000}, 8'h01, 1'b0, 4'hB);
        idle_step(1'b1);
        idle_step(1'b1);

        // Full message, LED shifting 1111 then zeros, then drain in order.
        do_reset();
        for (int i = 0; i < 15; i++) shift_char(seq[i], i < 4, 1'b0);
        for (int i = 0; i < 15; i++) idle_step(1'b1);
        idle_step(1'b1);

        // Multi-digit jump.
        do_reset();
        step(1'b1, 56'h0, 8'h00, 1'b0, 4'h0);

        // LED inconsistent with the shift; unknown glyph decodes as F.
        do_reset();
        step(1'b1, {m_prev_d[48:0], seg[11]}, 8'hA5, 1'b0, 4'hB);
        junk = 7'b1010101;
        step(1'b1, {m_prev_d[48:0], junk}, {m_prev_l[6:0], 1'b1}, 1'b0, 4'hF);
        step(1'b1, m_prev_d, m_prev_l ^ 8'h10, 1'b0, 4'h0);

        // Overflow then simultaneous push/pop at full.
        do_reset();
        for (int i = 0; i < 17; i++) shift_char(4'(i % 8), 1'b0, 1'b0);
        shift_char(4'h9, 1'b0, 1'b1);
        idle_step(1'b0);

        // Enable gating: held digits are compared after en returns.
        do_reset();
        shift_char(4'h1, 1'b0, 1'b0);
        step(1'b0, {m_prev_d[48:0], seg[2]}, m_prev_l, 1'b0, 4'h0);
        step(1'b0, {m_prev_d[41:0], seg[2], seg[3]}, m_prev_l, 1'b0, 4'h0);
        step(1'b1, {m_prev_d[41:0], seg[3], seg[4]}, m_prev_l, 1'b0, 4'h0);
        step(1'b0, {m_prev_d[48:0], seg[6]}, m_prev_l, 1'b0, 4'h0);
        shift_char(4'h7, 1'b0, 1'b0);

        // Pop while empty and a blank shifted into blanks both stay quiet.
        do_reset();
        idle_step(1'b1);
        shift_char(4'hD, 1'b0, 1'b1);

        // Asynchronous reset mid-stream drops pending pulse and FIFO contents.
        shift_char(4'h3, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bus.en = 1'b0; bus.digits_in = '1; bus.led_in = '0;
        idle_step(1'b0);
        idle_step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_stream_decoder.md
SEG_STREAM_DECODER -- requirements
Module: seg_stream_decoder

Interface
REQ-001 Parameter DEPTH, default 16, capture FIFO depth in entries (power of two, 4..64).
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  sample enable; when low, no sampling, detection or FIFO push.
REQ-005 digits_in  input  56  8 digits x 7 segments, active-low; digit 0 = [6:0] (newest), digit 7 = [55:49]; per digit bit0=a ... bit6=g.
REQ-006 led_in  input  8  LED bus accompanying the digit stream, newest at bit 0.
REQ-007 rd_en  input  1  FIFO pop request.
REQ-008 rd_data  output  4  FIFO head code, first-word-fall-through.
REQ-009 empty / full  output  1 each  FIFO status.
REQ-010 fifo_cnt  output  $clog2(DEPTH)+1  entries held.
REQ-011 overflow  output  1  sticky; set on dropped push.
REQ-012 char_code  output  4  last decoded character code (registered).
REQ-013 char_valid  output  1  one-cycle pulse, a new character was decoded.
REQ-014 shift_err  output  1  one-cycle pulse, digits changed but not by a one-digit left shift.
REQ-015 led_err  output  1  one-cycle pulse, LED bus inconsistent with digit shift.
REQ-016 char_cnt  output  16  decoded characters since reset, saturating at 16'hFFFF.

Function
REQ-017 Block SHALL hold prev_digits (56 b) and prev_led (8 b); updated to inputs every cycle en=1, held when en=0.
REQ-018 Per en=1 cycle, classification priority: (a) digits_in==prev_digits -> idle, no pulses; (b) digits_in[55:7]==prev_digits[48:0] -> shift event; (c) otherwise -> shift_err pulse next cycle.
REQ-019 Shift event: digits_in[6:0] decoded and presented on char_code with char_valid=1 on the following cycle (latency 1); code pushed to FIFO same edge.
REQ-020 Decode table (pattern -> code): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0010000->9, 0001000->A, 0000000->B, 1000001->C (glyph U), 1111111->D (space), 0111111->E (dash), any other->F.
REQ-021 Pattern 0000000 SHALL decode as B (code 8 not produced).
REQ-022 On a shift event, led_in[7:1] SHALL equal prev_led[6:0]; mismatch -> led_err pulse same cycle as char_valid; led_in changing outside a shift event (idle/no-shift cycles) -> led_err pulse.
REQ-023 A shift repeating identical content (e.g., all-blank shifting in blank) is indistinguishable and SHALL be treated as idle.
REQ-024 char_cnt SHALL increment on every shift event, saturating.
REQ-025 FIFO: push on shift event, pop on rd_en when not empty; rd_data = head combinationally; rd_data undefined-but-stable (holds last) when empty.
REQ-026 Push when full and no pop: entry dropped, overflow set, FIFO unchanged.
REQ-027 Push and pop same cycle when full: both performed, no overflow, fifo_cnt unchanged.
REQ-028 Pop when empty: ignored, fifo_cnt stays 0, no error.
REQ-029 Pointers wrap modulo DEPTH; full when fifo_cnt==DEPTH.

Reset
REQ-030 On rst: prev_digits=56'hFF_FFFF_FFFF_FFFF (all blank), prev_led=0, char_code=0, char_valid=0, shift_err=0, led_err=0, char_cnt=0, FIFO emptied (empty=1, full=0, fifo_cnt=0), overflow=0.
REQ-031 Reset mid-stream SHALL discard all pending pulses and FIFO contents immediately, no pulse on release.

Verification
REQ-032 After reset, en=1, digits_in={49'h1_FFFF_FFFF_FFFF,7'b0000000}, led_in=8'h01 -> next cycle char_valid=1, char_code=B, led_err=0, fifo_cnt=1, rd_data=B.
REQ-033 Feed sequence B,U,A,A,space,1,9,5,2,dash,2,0,2,5,space as successive shifts with LED 1111 then zeros -> codes B,C,A,A,D,1,9,5,2,E,2,0,2,5,D popped in order, char_cnt=15, no errors.
REQ-034 digits_in jumps from all-ones to 56'h0 -> shift_err=1 one cycle, no push, char_cnt unchanged.
REQ-035 Shift with led_in=8'hA5 after prev_led=8'h00 -> char_valid=1 and led_err=1 same cycle.
REQ-036 17 shifts without pop (DEPTH=16) -> full=1, overflow=1, fifo_cnt=16; then push with rd_en=1 -> fifo_cnt=16, overflow stays 1.
REQ-037 en=0 while digits_in shifts, then en=1 -> only one shift relative to held prev_digits evaluated; multi-digit jump reports shift_err.
